// File: rtl/npu_pkg.sv
// npu_pkg: types and defaults shared by the NPU stall controller slice.
//   npu_st_t          controller state encoding
//   NPU_CMD_W         default command/result width
//   NPU_TIMEOUT_DFLT  default WAIT-state timeout in cycles
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } npu_st_t;

  localparam int NPU_CMD_W        = 32;
  localparam int NPU_TIMEOUT_DFLT = 4096;

endpackage

// File: rtl/npu_timeout_cnt.sv
// npu_timeout_cnt: WAIT-state watchdog. Counts enabled cycles from zero and
// flags the cycle in which the count equals LIMIT-1.
//   clk      clock
//   reset_n  synchronous active-low reset
//   clear    force the count back to zero
//   enable   count this cycle
//   hit      count == LIMIT-1 (combinational from the count register)
module npu_timeout_cnt #(
  parameter int W     = 16,
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign hit = (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/npu_stall_ctrl.sv
// npu_stall_ctrl: holds the pipeline while an NPU command is issued over a
// req/ack handshake and its result returns, then emits a one-cycle
// writeback pulse.
//   clk, reset_n            clock, synchronous active-low reset
//   ex_npu_op, ex_npu_cmd   EX-stage NPU op valid and its command word
//   flush                   EX squash; only blocks a new issue from IDLE
//   npu_req, npu_cmd        request and latched command to the NPU
//   npu_ack                 NPU accepted the command
//   npu_done, npu_result    single-cycle result-valid and its data
//   npu_stall               freeze IF/ID/EX
//   wb_valid, wb_data       one-cycle writeback pulse; data held to next capture
//   npu_err                 sticky timeout flag
// Optional feature: define NPU_TIMEOUT_EN to build the WAIT-state timeout.
// Without it WAIT waits indefinitely and npu_err is tied low.
//
// state | meaning
// IDLE  | no op in flight; stall asserted combinationally on a new op
// REQ   | npu_req high, waiting for npu_ack
// WAIT  | command accepted, waiting for npu_done (or timeout)
// WB    | stall released, wb_valid pulses for one cycle
module npu_stall_ctrl
  import npu_pkg::*;
#(
  parameter int CMD_W   = NPU_CMD_W,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = NPU_TIMEOUT_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_npu_op,
  input  logic [CMD_W-1:0] ex_npu_cmd,
  input  logic             flush,
  output logic             npu_req,
  output logic [CMD_W-1:0] npu_cmd,
  input  logic             npu_ack,
  input  logic             npu_done,
  input  logic [CMD_W-1:0] npu_result,
  output logic             npu_stall,
  output logic             wb_valid,
  output logic [CMD_W-1:0] wb_data,
  output logic             npu_err
);

  if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
    $error("npu_stall_ctrl: TIMEOUT must be in 1 .. 2**TO_W-1");
  end

  npu_st_t state, state_nxt;
  logic    detect;
  logic    capture;
  logic    timed_out;
  logic    to_hit;

  // A squashed op never leaves IDLE, so flush only matters here.
  assign detect    = (state == IDLE) && ex_npu_op && !flush;
  assign npu_stall = detect || (state == REQ) || (state == WAIT);
  assign wb_valid  = (state == WB);

`ifdef NPU_TIMEOUT_EN
  // Held clear outside WAIT so the count starts at zero on WAIT entry.
  npu_timeout_cnt #(
    .W    (TO_W),
    .LIMIT(TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .hit    (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: if (detect) state_nxt = REQ;
      REQ: begin
        if (npu_ack) begin
          if (npu_done) begin
            capture   = 1'b1;
            state_nxt = WB;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (npu_done) begin
          capture   = 1'b1;
          state_nxt = WB;
        end else if (to_hit) begin
          timed_out = 1'b1;
          state_nxt = WB;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      npu_req <= 1'b0;
      npu_cmd <= '0;
      wb_data <= '0;
    end else begin
      state   <= state_nxt;
      npu_req <= (state_nxt == REQ);
      if (detect) npu_cmd <= ex_npu_cmd;
      if (capture) begin
        wb_data <= npu_result;
      end else if (timed_out) begin
        wb_data <= '0;
      end
    end
  end

`ifdef NPU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      npu_err <= 1'b0;
    end else if (timed_out) begin
      npu_err <= 1'b1;
    end
  end
`else
  assign npu_err = 1'b0;
`endif

endmodule
